sa_feeder: RTL and testbench

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_feeder.sv | 137 +++++++++++++
 tb/tb_sa_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sa_feeder.sv
// Systolic-array operand feeder: double buffer of NxN A/B tiles streamed as skewed diagonals.
// Optional SA_FEEDER_ACC_CLR_EN: pulse acc_clr on the first feed step of each run.

module sa_feeder_lane #(
  parameter int N    = 8,
  parameter int LANE = 0,
  parameter int SW   = 5,
  parameter int AW   = 6
) (
  input  logic [SW-1:0] step,
  input  logic          feed,
  output logic          vld,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr
);
  localparam logic [SW-1:0] LO = SW'(LANE + 1);
  localparam logic [SW-1:0] HI = SW'(LANE + N);

  logic [SW-1:0] k;

  // lane LANE sees element k = step-1-LANE of its diagonal while it is in range
  always_comb begin
    k      = step - LO;
    vld    = feed && (step >= LO) && (step <= HI);
    a_addr = AW'(LANE * N + int'(k));
    b_addr = AW'(int'(k) * N + LANE);
  end
endmodule

module sa_feeder #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int DRAIN = 2 * N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [$clog2(N*N)-1:0]  wr_addr,
  input  logic [DW-1:0]           wr_data,
  input  logic                    start,
  output logic [N*DW-1:0]         a_out,
  output logic [N*DW-1:0]         b_out,
  output logic [$clog2(2*N):0]    step,
  output logic                    busy,
  output logic                    done,
  output logic                    acc_clr
);
  localparam int AW  = $clog2(N * N);
  localparam int SW  = $clog2(2 * N) + 1;
  localparam int DCW = $clog2(DRAIN) + 1;
  localparam logic [SW-1:0]  LAST  = SW'(2 * N - 1);
  localparam logic [DCW-1:0] DLAST = DCW'(DRAIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} st_e;

  st_e                     state, state_nxt;
  logic [SW-1:0]           step_nxt;
  logic [DCW-1:0]          dcnt, dcnt_nxt;
  logic                    feed_nxt;
  logic [DW-1:0]           mem_a [N*N];
  logic [DW-1:0]           mem_b [N*N];
  logic [N-1:0]            vld;
  logic [N-1:0][AW-1:0]    a_addr, b_addr;
  logic [N-1:0][DW-1:0]    a_d, b_d, a_q, b_q;

  // tile buffers are deliberately not reset; they persist across aborts
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= '0;
      dcnt  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      dcnt  <= dcnt_nxt;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = '0;
    dcnt_nxt  = '0;
    case (state)
      S_IDLE:  if (start) begin
                 state_nxt = S_FEED;
                 step_nxt  = SW'(1);
               end
      S_FEED:  if (step == LAST) state_nxt = S_DRAIN;
               else              step_nxt  = step + SW'(1);
      S_DRAIN: if (dcnt == DLAST) state_nxt = S_DONE;
               else               dcnt_nxt  = dcnt + DCW'(1);
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign feed_nxt = (state_nxt == S_FEED);

  // lane data is selected from the next step so data and step register together
  for (genvar i = 0; i < N; i++) begin : g_lane
    sa_feeder_lane #(.N(N), .LANE(i), .SW(SW), .AW(AW)) u_lane (
      .step   (step_nxt),
      .feed   (feed_nxt),
      .vld    (vld[i]),
      .a_addr (a_addr[i]),
      .b_addr (b_addr[i])
    );
    assign a_d[i] = vld[i] ? mem_a[a_addr[i]] : '0;
    assign b_d[i] = vld[i] ? mem_b[b_addr[i]] : '0;
  end

  always_comb begin
    busy    = (state == S_FEED) || (state == S_DRAIN);
    done    = (state == S_DONE);
    acc_clr = 1'b0;
`ifdef SA_FEEDER_ACC_CLR_EN
    acc_clr = (state == S_FEED) && (step == SW'(1));
`else
    acc_clr = 1'b0;
`endif
  end

  assign a_out = a_q;
  assign b_out = b_q;
endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: an N=8 instance for the main schedule and an N=2 instance
// for the small hand-worked schedule.
module tb_sa_feeder;
  localparam bit ACC =
`ifdef SA_FEEDER_ACC_CLR_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en8, wr_sel8, start8, busy8, done8, acc8;
  logic [5:0]  wr_addr8;
  logic [7:0]  wr_data8;
  logic [63:0] a8, b8;
  logic [4:0]  step8;
  logic        wr_en2, wr_sel2, start2, busy2, done2, acc2;
  logic [1:0]  wr_addr2;
  logic [7:0]  wr_data2;
  logic [15:0] a2, b2;
  logic [2:0]  step2;

  sa_feeder #(.N(8), .DW(8), .DRAIN(16)) u8 (
    .clk(clk), .rst(rst), .wr_en(wr_en8), .wr_sel(wr_sel8), .wr_addr(wr_addr8),
    .wr_data(wr_data8), .start(start8), .a_out(a8), .b_out(b8), .step(step8),
    .busy(busy8), .done(done8), .acc_clr(acc8));

  sa_feeder #(.N(2), .DW(8)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .start(start2), .a_out(a2), .b_out(b2), .step(step2),
    .busy(busy2), .done(done2), .acc_clr(acc2));

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  st;
    logic        bz;
    logic        dn;
    logic        ac;
  } obs_t;

  obs_t     q[$];
  int       total = 0;
  int       bad = 0;
  bit [7:0] ma[64];
  bit [7:0] mb[64];

  function automatic obs_t mk(input logic [63:0] a, input logic [63:0] b, input int st,
                              input bit bz, input bit dn, input bit ac);
    obs_t o;
    o.a = a; o.b = b; o.st = 5'(st); o.bz = bz; o.dn = dn; o.ac = ac;
    return o;
  endfunction

  function automatic obs_t cur(input bit sel);
    obs_t o;
    if (sel) begin
      o.a = {48'b0, a2}; o.b = {48'b0, b2}; o.st = {2'b0, step2};
      o.bz = busy2; o.dn = done2; o.ac = acc2;
    end else begin
      o.a = a8; o.b = b8; o.st = step8; o.bz = busy8; o.dn = done8; o.ac = acc8;
    end
    return o;
  endfunction

  // expected N=8 lanes at feed step t: lane i carries diagonal element t-1-i
  function automatic obs_t feed8(input int t);
    logic [63:0] a, b;
    a = '0; b = '0;
    for (int i = 0; i < 8; i++) begin
      int k;
      k = t - 1 - i;
      if (k >= 0 && k <= 7) begin
        a[i*8 +: 8] = ma[i*8 + k];
        b[i*8 +: 8] = mb[k*8 + i];
      end
    end
    return mk(a, b, t, 1'b1, 1'b0, ACC && (t == 1));
  endfunction

  task automatic chk(input bit sel, input string tag, input obs_t e);
    obs_t o;
    o = cur(sel);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got a=%h b=%h step=%0d busy=%b done=%b acc=%b, expected a=%h b=%h step=%0d busy=%b done=%b acc=%b",
             tag, o.a, o.b, o.st, o.bz, o.dn, o.ac, e.a, e.b, e.st, e.bz, e.dn, e.ac);
    end
  endtask

  task automatic push_run8();
    for (int t = 1; t <= 15; t++) q.push_back(feed8(t));
    for (int d = 0; d < 16; d++) q.push_back(mk('0, '0, 0, 1'b1, 1'b0, 1'b0));
    q.push_back(mk('0, '0, 0, 1'b0, 1'b1, 1'b0));
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic wr(input bit sel, input bit bs, input int addr, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin
      wr_en2 = 1'b1; wr_sel2 = bs; wr_addr2 = 2'(addr); wr_data2 = d;
    end else begin
      wr_en8 = 1'b1; wr_sel8 = bs; wr_addr8 = 6'(addr); wr_data8 = d;
    end
    @(posedge clk);
    #1;
    wr_en2 = 1'b0;
    wr_en8 = 1'b0;
  endtask

  task automatic go(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1;
    else     start8 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start8 = 1'b0;
  endtask

  // pop one expectation per cycle; optionally hammer start/wr_en during FEED
  task automatic run_q(input bit sel, input string tag, input bit intf, input int rel);
    obs_t e;
    int   i;
    i = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk(sel, tag, e);
      if (intf && i >= 1 && i <= 4) begin
        start8 = 1'b1; wr_en8 = 1'b1; wr_sel8 = i[0]; wr_addr8 = 6'(i * 9); wr_data8 = 8'hFF;
      end else if (intf) begin
        start8 = 1'b0; wr_en8 = 1'b0;
      end
      if (i == rel) start8 = 1'b0;
      i++;
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en8 = 0; wr_sel8 = 0; wr_addr8 = '0; wr_data8 = '0; start8 = 0;
    wr_en2 = 0; wr_sel2 = 0; wr_addr2 = '0; wr_data2 = '0; start2 = 0;
    @(negedge clk);
    chk(0, "reset8", mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    chk(1, "reset2", mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r*8+c] = 8'(8*r + c);
        mb[r*8+c] = 8'(64 + 8*r + c);
        wr(0, 1'b0, r*8+c, ma[r*8+c]);
        wr(0, 1'b1, r*8+c, mb[r*8+c]);
      end
    for (int k = 0; k < 4; k++) begin
      wr(1, 1'b0, k, 8'(k + 1));
      wr(1, 1'b1, k, 8'(k + 5));
    end

    // N=2 hand-worked schedule, DRAIN defaults to 4
    go(1);
    q.push_back(mk(64'h0001, 64'h0005, 1, 1'b1, 1'b0, ACC));
    q.push_back(mk(64'h0302, 64'h0607, 2, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(64'h0400, 64'h0800, 3, 1'b1, 1'b0, 1'b0));
    for (int d = 0; d < 4; d++) q.push_back(mk('0, '0, 0, 1'b1, 1'b0, 1'b0));
    q.push_back(mk('0, '0, 0, 1'b0, 1'b1, 1'b0));
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    run_q(1, "n2", 1'b0, -1);

    go(0); push_run8(); run_q(0, "run1", 1'b0, -1);
    go(0); push_run8(); run_q(0, "intf", 1'b1, -1);
    go(0); push_run8(); run_q(0, "rerun", 1'b0, -1);

    // abort at step 3
    go(0);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      chk(0, "pre_rst", feed8(t));
    end
    rst = 1'b1;
    #1 chk(0, "rst_abort", mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(0, "post_rst", mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    end
    go(0); push_run8(); run_q(0, "replay", 1'b0, -1);

    // start held high: one IDLE cycle between runs
    go(0);
    start8 = 1'b1;
    push_run8();
    push_run8();
    run_q(0, "b2b", 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
